// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// sign-corrected {remainder, quotient} held on result_o until EX releases start_i.
module div_iter #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam logic [1:0] S_FREE   = 2'b00;
    localparam logic [1:0] S_BYZERO = 2'b01;
    localparam logic [1:0] S_ON     = 2'b10;
    localparam logic [1:0] S_END    = 2'b11;

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quot;
    logic              neg_a;
    logic              neg_b;
    logic              is_signed;
    logic [DATA_W:0]   partial;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quot_next;
    logic              accept;

    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                    input logic take);
        return (take && (v < 0)) ? -v : v;
    endfunction

    function automatic logic [DATA_W-1:0] negate_if(input logic signed [DATA_W-1:0] v,
                                                    input logic cond);
        return cond ? -v : v;
    endfunction

    assign accept = (state == S_FREE) && start_i && !annul_i;

    // Trial subtraction: a set top bit of the (DATA_W+1)-bit difference means borrow, so restore.
    always_comb begin
        partial   = {rem, dividend[DATA_W-1]};
        diff      = partial - {1'b0, divisor};
        rem_next  = partial[DATA_W-1:0];
        quot_next = {quot[DATA_W-2:0], 1'b0};
        if (!diff[DATA_W]) begin
            rem_next  = diff[DATA_W-1:0];
            quot_next = {quot[DATA_W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_FREE;
            count    <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                S_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    count    <= '0;
                    if (accept)
                        state <= (opdata2_i == '0) ? S_BYZERO : S_ON;
                end
                S_BYZERO: begin
                    state    <= S_END;
                    ready_o  <= 1'b1;
                    result_o <= '0;
                end
                S_ON: begin
                    if (annul_i || !start_i) begin
                        state <= S_FREE;
                    end else begin
                        count <= count + 1'b1;
                        if (count == CNT_W'(DATA_W - 1)) begin
                            state    <= S_END;
                            ready_o  <= 1'b1;
                            result_o <= {negate_if(rem_next, is_signed && neg_a),
                                         negate_if(quot_next, is_signed && (neg_a ^ neg_b))};
                        end
                    end
                end
                default: begin
                    if (annul_i || !start_i) begin
                        state    <= S_FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
            endcase
        end
    end

    // Working registers carry no reset; they are always loaded on acceptance before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            dividend  <= magnitude(opdata1_i, signed_div_i);
            divisor   <= magnitude(opdata2_i, signed_div_i);
            rem       <= '0;
            quot      <= '0;
            neg_a     <= opdata1_i[DATA_W-1];
            neg_b     <= opdata2_i[DATA_W-1];
            is_signed <= signed_div_i;
        end else if (state == S_ON) begin
            dividend <= dividend << 1;
            rem      <= rem_next;
            quot     <= quot_next;
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Randomized self-checking bench for div_iter against a plain-arithmetic division model.
module tb_div_iter;

    localparam int DATA_W = 32;

    logic        clk = 1'b0;
    logic        resetn;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_iter #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Truncating division done in 64 bits so the most-negative / -1 case just wraps.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called at a negedge in cycle 0; scrambles operands while busy.
    task automatic wait_ready(input int bound, output int lat, output logic [63:0] res);
        bit done;
        done = 0;
        lat  = 999;
        res  = 'x;
        for (int n = 1; n <= bound && !done; n++) begin
            @(posedge clk);
            @(negedge clk);
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom);
            if (ready_o) begin
                lat  = n;
                res  = result_o;
                done = 1;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input int hold);
        int          lat;
        logic [63:0] res;
        logic [63:0] exp;
        exp          = model(a, b, sgn);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
        wait_ready(40, lat, res);
        check({tag, "_lat"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
        check({tag, "_res"}, res, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
            check({tag, "_hold_res"}, result_o, exp);
        end
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
        check({tag, "_drop_res"}, result_o, 64'd0);
    endtask

    initial begin
        int          lat;
        logic [63:0] res;
        logic        seen_rdy;
        logic [31:0] ra, rb;
        logic        rs;

        resetn       = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (2) @(negedge clk);
        check("reset_rdy", 64'(ready_o), 64'd0);
        check("reset_res", result_o, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        do_op("u100_7", 32'd100, 32'd7, 1'b0, 3);
        do_op("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        do_op("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
        do_op("s_zero", 32'd1234, 32'd0, 1'b1, 1);
        do_op("u_zero", 32'hDEAD_BEEF, 32'd0, 1'b0, 0);
        do_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);

        // Annul in cycle 10 of ON, then restart straight from the FREE cycle.
        opdata1_i    = 32'd5000;
        opdata2_i    = 32'd3;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        seen_rdy     = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            @(negedge clk);
            seen_rdy = seen_rdy | ready_o;
        end
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        seen_rdy = seen_rdy | ready_o;
        check("annul_no_rdy", 64'(seen_rdy), 64'd0);
        annul_i      = 1'b0;
        opdata1_i    = 32'hFFFF_FFFF;
        opdata2_i    = 32'd16;
        signed_div_i = 1'b0;
        wait_ready(40, lat, res);
        check("annul_restart_lat", 64'(lat), 64'd33);
        check("annul_restart_res", res, 64'h0000_000F_0FFF_FFFF);
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Asynchronous reset mid-ON, then a normal operation proves the FSM is back in FREE.
        opdata1_i    = 32'd999;
        opdata2_i    = 32'd9;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 resetn = 1'b0;
        #1;
        check("rst_on_rdy", 64'(ready_o), 64'd0);
        check("rst_on_res", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        resetn  = 1'b1;
        @(negedge clk);
        do_op("post_rst", 32'd81, 32'd9, 1'b0, 0);

        // Asynchronous reset while holding a result clears outputs before any clock edge.
        opdata1_i    = 32'd77;
        opdata2_i    = 32'd5;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        wait_ready(40, lat, res);
        check("rst_end_pre", res, 64'h0000_0002_0000_000F);
        #2 resetn = 1'b0;
        #1;
        check("rst_end_rdy", 64'(ready_o), 64'd0);
        check("rst_end_res", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        resetn  = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 40);
                2: rb = rs ? 32'hFFFF_FFFF - $urandom_range(0, 20) : $urandom_range(1, 1000);
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rs = 1'b1; end
                default: ;
            endcase
            do_op("rand", ra, rb, rs, i % 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
